// File: rtl/pipe_reg_ex_mem_elastic.sv
// Elastic EX->MEM pipeline register.
// A main register drives the MEM-side outputs; a single skid register absorbs
// the one entry EX may launch in the cycle MEM first stalls. in_ready depends
// on the FSM state only, so no combinational path runs from MEM back into EX.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high on that side. The producer must hold valid and its data stable
// until ready is seen. The consumer may change ready freely. While out_valid is
// high and out_ready is low, out_rd and out_alu do not change. flush overrides
// both transfers in its cycle and empties the register.
module pipe_reg_ex_mem_elastic #(
    parameter int RD_W   = 2,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_alu,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_alu,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e              state_q;
    logic                out_valid_q;
    logic                in_ready_q;
    logic [RD_W-1:0]     main_rd_q;
    logic [DATA_W-1:0]   main_alu_q;
    logic [RD_W-1:0]     skid_rd_q;
    logic [DATA_W-1:0]   skid_alu_q;

    logic                ix;
    logic                ox;

    // Transfers are qualified with the registered handshake outputs.
    assign ix = in_valid & in_ready_q;
    assign ox = out_valid_q & out_ready;

    // State, storage and registered handshake outputs updated together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_rd_q   <= '0;
            main_alu_q  <= '0;
            skid_rd_q   <= '0;
            skid_alu_q  <= '0;
        end else if (flush) begin
            // Squash everything held plus whatever EX offers this cycle.
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_rd_q   <= '0;
            main_alu_q  <= '0;
            skid_rd_q   <= '0;
            skid_alu_q  <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (ix) begin
                        main_rd_q   <= in_rd;
                        main_alu_q  <= in_alu;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (ix && ox) begin
                        // Streaming: replace the departing entry directly.
                        main_rd_q  <= in_rd;
                        main_alu_q <= in_alu;
                    end else if (ix) begin
                        // MEM stalled: park the new entry and close the input.
                        skid_rd_q  <= in_rd;
                        skid_alu_q <= in_alu;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_FULL;
                    end else if (ox) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (ox) begin
                        main_rd_q  <= skid_rd_q;
                        main_alu_q <= skid_alu_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_BUSY;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_rd      = main_rd_q;
    assign out_alu     = main_alu_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipe_reg_ex_mem_elastic.sv
// Bench for pipe_reg_ex_mem_elastic (RD_W=3, DATA_W=32).
// The reference model is a queue of accepted entries: MEM must see exactly
// that sequence, out_valid means "queue non-empty", in_ready means "fewer
// than two entries held", and flush/reset empty the queue.
module tb_pipe_reg_ex_mem_elastic;

    localparam int RD_W   = 3;
    localparam int DATA_W = 32;
    localparam int EW     = RD_W + DATA_W;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [RD_W-1:0]   in_rd;
    logic [DATA_W-1:0] in_alu;
    logic              out_valid;
    logic              out_ready;
    logic [RD_W-1:0]   out_rd;
    logic [DATA_W-1:0] out_alu;
    logic [1:0]        dbg_state;

    pipe_reg_ex_mem_elastic #(.RD_W(RD_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rd       (in_rd),
        .in_alu      (in_alu),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_alu     (out_alu),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [EW-1:0]     exp_q[$];
    int                n_vec;
    int                n_err;
    bit                mon_en;
    bit                zero_f;
    bit                prev_stall;
    logic [RD_W-1:0]   prev_rd;
    logic [DATA_W-1:0] prev_alu;
    int                pushed;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Driver: sets inputs 2 time units after the edge; records accepted entries.
    task automatic drive(input bit fl, input bit iv, input logic [RD_W-1:0] rd,
                         input logic [DATA_W-1:0] alu, input bit ordy);
        @(posedge clk);
        #2;
        flush     = fl;
        in_valid  = iv;
        in_rd     = rd;
        in_alu    = alu;
        out_ready = ordy;
        if (iv && in_ready && !fl) begin
            exp_q.push_back({rd, alu});
            pushed++;
        end
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, 1'b0, '0, '0, ordy);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_rd"},    64'(out_rd),    64'd0);
        chk({tag, "_out_alu"},   64'(out_alu),   64'd0);
    endtask

    // Monitor: checks outputs just after each edge, then books the handshake
    // that the coming edge will perform.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
                chk("in_ready",  64'(in_ready),  64'(exp_q.size() < 2));
                if (out_valid && exp_q.size() > 0) begin
                    chk("out_rd",  64'(out_rd),  64'(exp_q[0][EW-1:DATA_W]));
                    chk("out_alu", 64'(out_alu), 64'(exp_q[0][DATA_W-1:0]));
                end
                if (!out_valid && zero_f) begin
                    chk("cleared_rd",  64'(out_rd),  64'd0);
                    chk("cleared_alu", 64'(out_alu), 64'd0);
                end
                if (prev_stall) begin
                    chk("stall_rd",  64'(out_rd),  64'(prev_rd));
                    chk("stall_alu", 64'(out_alu), 64'(prev_alu));
                end
            end
            @(negedge clk);
            if (mon_en) begin
                prev_stall = out_valid && !out_ready && !flush;
                prev_rd    = out_rd;
                prev_alu   = out_alu;
                if (flush) begin
                    exp_q.delete();
                    zero_f = 1'b1;
                end else begin
                    if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                    if (in_valid && in_ready) zero_f = 1'b0;
                end
            end
        end
    end

    // Stimulus sequence
    initial begin
        n_vec = 0; n_err = 0; pushed = 0;
        mon_en = 1'b0; zero_f = 1'b1; prev_stall = 1'b0;
        prev_rd = '0; prev_alu = '0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_rd = '0; in_alu = '0; out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        @(posedge clk);
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single push then an 8-entry back-to-back stream with MEM always ready.
        drive(1'b0, 1'b1, 3'd1, 32'h5A, 1'b1);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 3'(i), 32'(i), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Stall: A held, push B into the skid, hold, then release in order.
        drive(1'b0, 1'b1, 3'd2, 32'hAAAA_0001, 1'b0);
        drive(1'b0, 1'b1, 3'd3, 32'hBBBB_0002, 1'b0);
        drive(1'b0, 1'b1, 3'd4, 32'hCCCC_0003, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush while FULL with a new entry offered: nothing survives.
        drive(1'b0, 1'b1, 3'd5, 32'h1111_1111, 1'b0);
        drive(1'b0, 1'b1, 3'd6, 32'h2222_2222, 1'b0);
        drive(1'b1, 1'b1, 3'd7, 32'h3333_3333, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset mid-stream, checked before the next edge.
        drive(1'b0, 1'b1, 3'd1, 32'hDEAD_BEEF, 1'b0);
        drive(1'b0, 1'b1, 3'd2, 32'hFEED_F00D, 1'b0);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check_reset_values("async_rst");
        exp_q.delete();
        zero_f     = 1'b1;
        prev_stall = 1'b0;
        in_valid   = 1'b0;
        @(posedge clk);
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Random traffic, occasional flush.
        pushed = 0;
        for (int cyc = 0; cyc < 20000 && pushed < 1000; cyc++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)),
                  32'($urandom),
                  ($urandom_range(0, 3) != 0));
        end
        chk("rand_budget", 64'(pushed >= 1000), 64'd1);

        // Drain and confirm nothing is left behind.
        repeat (4) idle(1'b1);
        @(posedge clk);
        #3;
        chk("drain_model_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid",   64'(out_valid),    64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
